ro_sync_axil_regs: RTL
======================

RO_SYNC_AXIL_REGS -- requirements
Module: ro_sync_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width; register index = addr[3:2].
REQ-003 SHALL have ports, one clock and asynchronous active-low reset: ACLK in 1 clock; ARESETN in 1 async active-low reset.
REQ-004 AWADDR in 4 write address; AWPROT in 3 ignored; AWVALID in 1; AWREADY out 1.
REQ-005 WDATA in 32; WSTRB in 4 byte enables; WVALID in 1; WREADY out 1.
REQ-006 BRESP out 2; BVALID out 1; BREADY in 1.
REQ-007 ARADDR in 4; ARPROT in 3 ignored; ARVALID in 1; ARREADY out 1.
REQ-008 RDATA out 32; RRESP out 2; RVALID out 1; RREADY in 1.
REQ-009 regs_o out 128 concatenated register file, reg0 at [31:0]; wr_pulse_o out 4 one-cycle strobe per register written.

Function
REQ-010 Write FSM SHALL have states W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-011 AWREADY SHALL be 1 only in W_IDLE/W_HAVE_W; WREADY only in W_IDLE/W_HAVE_AW; both 0 in W_RESP.
REQ-012 W_IDLE: AW and W handshakes in same cycle -> register write at that edge, next state W_RESP; AW only -> W_HAVE_AW (address latched); W only -> W_HAVE_W (data+strobe latched).
REQ-013 W_HAVE_AW on W handshake, or W_HAVE_W on AW handshake, SHALL write the register and go to W_RESP.
REQ-014 BVALID SHALL assert the cycle after the completing handshake and hold with BRESP=2'b00 until BREADY; on BVALID&&BREADY go to W_IDLE.
REQ-015 Register write SHALL update only bytes with WSTRB[n]=1; WSTRB=0 leaves register unchanged but still returns OKAY.
REQ-016 wr_pulse_o[idx] SHALL pulse high exactly one cycle, coincident with BVALID rising, whenever WSTRB!=0.
REQ-017 Read FSM SHALL have states R_IDLE (ARREADY=1) and R_DATA (RVALID=1, RRESP=2'b00).
REQ-018 On AR handshake RDATA SHALL be registered from reg[ARADDR[3:2]] and RVALID asserted next cycle; RDATA stable until RVALID&&RREADY, then R_IDLE.
REQ-019 Read-to-data latency SHALL be exactly 1 cycle; back-to-back reads every 2 cycles with RREADY held high.
REQ-020 Same-edge AR handshake and register write to same index SHALL return the pre-write value.
REQ-021 Read and write channels SHALL operate independently; one outstanding transaction per channel.
REQ-022 ARADDR/AWADDR bits [1:0] SHALL be ignored; all indices 0-3 valid; no SLVERR/DECERR ever issued.

Reset
REQ-023 ARESETN low SHALL asynchronously force both FSMs to idle, all registers to 32'h0, BVALID/RVALID/wr_pulse_o to 0, RDATA to 0.
REQ-024 AWREADY/WREADY/ARREADY SHALL be 0 while ARESETN low and rise on the first ACLK rising edge after release (gated by a reset-done flop).
REQ-025 Reset mid-transaction SHALL discard latched address/data with no register update; no BVALID/RVALID afterwards for that transaction.

Structure
REQ-026 Package ro_sync_axil_pkg SHALL hold write/read state enums, RESP_OKAY=2'b00, NUM_REGS=4, IDX_W=2.
REQ-027 Sub-module ro_sync_strb_merge (old word, new word, strobe -> merged word) SHALL be the only sub-module.

Verification
REQ-028 Write 1,2,3,4 to 0x0,0x4,0x8,0xC, WSTRB=F, then read back -> RDATA 1,2,3,4, all BRESP/RRESP=00, regs_o=0x00000004_00000003_00000002_00000001.
REQ-029 Write 0xAABBCCDD to 0x0 then 0x11223344 WSTRB=0101 -> read 0x0 returns 0xAA22CC44; wr_pulse_o[0] pulsed twice.
REQ-030 WVALID 3 cycles before AWVALID (0x8, data 0x5A) -> WREADY low after W handshake until AW accepted; BVALID 1 cycle after AW handshake; reg2=0x5A.
REQ-031 BREADY held low 10 cycles -> BVALID and BRESP stable, AWREADY/WREADY 0 throughout; next write accepted after BREADY.
REQ-032 reg1=7; same-edge AR(0x4) and write 9 to 0x4 -> RDATA=7, subsequent read =9.
REQ-033 ARESETN pulsed low while in W_HAVE_AW -> no register change, BVALID stays 0, readies 0 then 1 one edge after release, regs_o=0.

Source files
------------

// File: rtl/ro_sync_axil_pkg.sv
// ro_sync_axil_pkg
// Shared types and constants for the ro_sync AXI4-Lite register block:
// write/read channel state encodings, the OKAY response code and the
// register-file geometry (four 32-bit registers, 2-bit index).
package ro_sync_axil_pkg;

    localparam int         NUM_REGS  = 4;
    localparam int         IDX_W     = 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/ro_sync_strb_merge.sv
// ro_sync_strb_merge
// Byte-lane merge: each byte of merged_word comes from new_word when its
// strobe bit is set, otherwise from old_word.
//   old_word    in  DATA_W    current register contents
//   new_word    in  DATA_W    incoming write data
//   strb        in  DATA_W/8  byte enables
//   merged_word out DATA_W    value to store
module ro_sync_strb_merge #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_word,
    input  logic [DATA_W-1:0]   new_word,
    input  logic [DATA_W/8-1:0] strb,
    output logic [DATA_W-1:0]   merged_word
);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and a latch is never inferred.
    always_comb begin
        merged_word = old_word;
        for (int n = 0; n < DATA_W/8; n++) begin
            if (strb[n]) begin
                merged_word[n*8 +: 8] = new_word[n*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/ro_sync_axil_regs.sv
// ro_sync_axil_regs
// AXI4-Lite slave exposing four 32-bit read/write registers.
//   ACLK, ARESETN           clock, asynchronous active-low reset
//   AW*/W*/B*               write address, data and response channels
//   AR*/R*                  read address and data channels
//   regs_o                  whole register file, reg0 at [31:0]
//   wr_pulse_o              one-cycle strobe per register actually written
// Address bits [1:0] and the PROT inputs are ignored; every response is OKAY.
module ro_sync_axil_regs
    import ro_sync_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          AWADDR,
    input  logic [2:0]                             AWPROT,
    input  logic                                   AWVALID,
    output logic                                   AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                                   WVALID,
    output logic                                   WREADY,
    output logic [1:0]                             BRESP,
    output logic                                   BVALID,
    input  logic                                   BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          ARADDR,
    input  logic [2:0]                             ARPROT,
    input  logic                                   ARVALID,
    output logic                                   ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                             RRESP,
    output logic                                   RVALID,
    input  logic                                   RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]                    wr_pulse_o
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

    logic              rst_done;
    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DW-1:0]     wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic [DW-1:0]     regs [NUM_REGS];

    logic              aw_hs, w_hs, ar_hs, do_write;
    logic [IDX_W-1:0]  wr_idx;
    logic [DW-1:0]     wr_data, merged;
    logic [STRB_W-1:0] wr_strb;
    logic              unused_inputs;

    assign unused_inputs = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Holds all ready outputs low until the first clock edge after reset
    // release, so no handshake can land while reset is still settling.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rst_done <= 1'b0;
        else          rst_done <= 1'b1;
    end

    // ---------------- write channel ----------------
    assign AWREADY = rst_done && (w_state == W_IDLE || w_state == W_HAVE_W);
    assign WREADY  = rst_done && (w_state == W_IDLE || w_state == W_HAVE_AW);
    assign BVALID  = (w_state == W_RESP);
    assign BRESP   = RESP_OKAY;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;

    // Selects the address/data pair for the write: live bus values for the
    // half arriving this cycle, latched values for the half that came earlier.
    always_comb begin
        w_next   = w_state;
        do_write = 1'b0;
        wr_idx   = aw_idx_q;
        wr_data  = wdata_q;
        wr_strb  = wstrb_q;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    do_write = 1'b1;
                    wr_idx   = AWADDR[IDX_W+1:2];
                    wr_data  = WDATA;
                    wr_strb  = WSTRB;
                    w_next   = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_HAVE_AW;
                end else if (w_hs) begin
                    w_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    do_write = 1'b1;
                    wr_data  = WDATA;
                    wr_strb  = WSTRB;
                    w_next   = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    do_write = 1'b1;
                    wr_idx   = AWADDR[IDX_W+1:2];
                    w_next   = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state  <= W_IDLE;
            aw_idx_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            w_state <= w_next;
            if (aw_hs) aw_idx_q <= AWADDR[IDX_W+1:2];
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end
        end
    end

    ro_sync_strb_merge #(.DATA_W(DW)) u_merge (
        .old_word    (regs[wr_idx]),
        .new_word    (wr_data),
        .strb        (wr_strb),
        .merged_word (merged)
    );

    // The pulse is registered alongside the write, so it rises with BVALID.
    // NOTE: the register file is only four words of flops, so it is reset
    // like any other state; a RAM-sized array would be left unreset.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_pulse_o <= '0;
        end else begin
            wr_pulse_o <= '0;
            if (do_write && (wr_strb != '0)) begin
                regs[wr_idx] <= merged;
                wr_pulse_o   <= {{(NUM_REGS-1){1'b0}}, 1'b1} << wr_idx;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_o
        assign regs_o[g*DW +: DW] = regs[g];
    end

    // ---------------- read channel ----------------
    assign ARREADY = rst_done && (r_state == R_IDLE);
    assign RVALID  = (r_state == R_DATA);
    assign RRESP   = RESP_OKAY;
    assign ar_hs   = ARVALID && ARREADY;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)  r_next = R_DATA;
            R_DATA:  if (RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // RDATA samples the register file before any same-edge write lands, so a
    // colliding read returns the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            RDATA   <= '0;
        end else begin
            r_state <= r_next;
            if (ar_hs) RDATA <= regs[ARADDR[IDX_W+1:2]];
        end
    end

endmodule
